fp_subtractor_seq: RTL
======================

Name: fp_subtractor_seq

Overview:
- Multi-cycle, clocked single-precision IEEE-754 subtractor: result = number1 − number2.
- Companion to the combinational ADDF adder in the execute stage. Implements the inverse operation, SUBF, by negating operand 2 and using an align/add/normalize datapath.
- Normalization is iterative: one shift per clock, tracked by a state machine.
- The pipeline starts the unit with a start pulse and stalls on busy until done.

Parameters:
- SUBF, 6'b011000, opcode that launches an operation.
- MAX_NORM, 24, upper bound on left-normalize iterations.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- opcode_d1  input  6  decoded opcode; the operation launches only if it equals SUBF while start=1.
- number1  input  32  minuend (IEEE-754 single); latched on launch.
- number2  input  32  subtrahend; latched on launch.
- result  output  32  difference; held stable from done until the next launch.
- busy  output  1  high from the launch edge until the done cycle, inclusive.
- done  output  1  single-cycle pulse: result is valid.
- overflow  output  1  sticky per operation; set when the exponent overflows.
- underflow  output  1  sticky per operation; set when the exponent underflows.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - result=32'h0, busy=0, done=0, overflow=0, underflow=0.
  - Asserting reset mid-operation aborts it immediately; no done is produced.
- Operand handling:
  - Exponent field 0 is treated as exact zero (no denormals): mantissa=0.
  - Otherwise mantissa = {1'b1, frac} (24 bits).
  - Operand 2 sign is inverted at latch.
  - Exponent arithmetic is 10-bit signed internally.
- IDLE:
  - On (start && opcode_d1==SUBF), latch the operands, set busy=1, clear the flags, go to ALIGN.
  - start with any other opcode is ignored.
- ALIGN (1 cycle):
  - Order the operands by magnitude ({exp, mant}); the larger is A, the smaller is B.
  - Shift B right by diff=expA−expB; if diff≥25, B=0.
  - Working exponent = expA.
- ADD (1 cycle):
  - Equal signs: 25-bit sum = A + B.
  - Unequal signs: A − B (never negative).
  - Result sign = sign of A.
- NORM:
  - Mantissa == 0: force result +0 (sign 0, exp 0) and go to PACK.
  - Bit 24 set: shift right 1, exp+1, then PACK (one cycle).
  - Else, while bit 23 == 0: shift left 1 and decrement exp, one per cycle, bounded by MAX_NORM; then PACK.
  - Bits shifted out on the right are truncated (round toward zero).
- PACK (1 cycle):
  - exp ≥ 255: result={sign, 8'hFF, 23'h0}, overflow=1.
  - exp ≤ 0 on a nonzero mantissa: result=+0, underflow=1.
  - Else result={sign, exp[7:0], mant[22:0]}.
- DONE (1 cycle):
  - done=1, busy=1, then return to IDLE.
  - busy drops on the following edge.
  - start is not accepted in DONE.
- Latency:
  - Launch edge = edge 0; done is high after edge 4+s, where s = number of NORM left shifts.
  - Zero and right-shift cases have s=0.
- Simultaneous events:
  - start while busy: ignored, with no queueing.
  - A new operand value during busy has no effect.
  - Back-to-back operations: the earliest next launch is the edge after the done cycle.
- NaN and Inf inputs (exp=255) are not special-cased; the result is unspecified but the FSM must complete.

Test Plan:
- Basic subtraction: 0x40400000 − 0x3F800000 (3.0−1.0) → result 0x40000000, done high exactly 4 cycles after the launch edge, flags 0.
- Sign flip with one normalization shift: 0x3F800000 − 0x3FC00000 (1.0−1.5) → 0xBF000000, done at launch+5.
- Exact cancellation and operand-sign mixing:
  - 0x3F800000 − 0x3F800000 → 0x00000000, done at launch+4.
  - 0x3F800000 − 0xBF800000 → 0x40000000 (right-normalize path).
- Overflow: 0x7F7FFFFF − 0xFF7FFFFF → 0x7F800000, overflow=1. A following normal operation clears overflow.
- Protocol and reset:
  - start with opcode ADDF (6'b010111) → no busy.
  - start pulsed during busy → ignored; the first result is unchanged.
  - reset_n dropped during NORM → all outputs 0 immediately, state IDLE, and the next launch completes correctly.

Source files
------------

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (SUBF).
// Align/add in fixed steps, then iterative one-bit-per-clock normalization.
module fp_subtractor_seq #(
    parameter logic [5:0] SUBF     = 6'b011000,
    parameter int         MAX_NORM = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  opcode_d1,
    input  logic [31:0] number1,
    input  logic [31:0] number2,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [4:0] NORM_LIM = 5'(MAX_NORM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_PACK,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic               s1_q, s2_q;
    logic signed [9:0]  e1_q, e2_q;
    logic [23:0]        m1_q, m2_q;
    logic               w_sign_q;
    logic signed [9:0]  w_exp_q;
    logic [24:0]        w_mant_q;
    logic [4:0]         norm_cnt_q;

    logic launch;
    logic norm_exit;
    assign launch = start && (opcode_d1 == SUBF);
    assign norm_exit = (w_mant_q == 25'h0) || w_mant_q[24] ||
                       w_mant_q[23] || (norm_cnt_q == NORM_LIM);

    // Magnitude ordering and alignment of the smaller operand
    logic               swap;
    logic               big_s, sml_s;
    logic signed [9:0]  big_e, sml_e, diff;
    logic [23:0]        big_m, sml_m, sml_sh;

    always_comb begin
        swap   = {e2_q[7:0], m2_q} > {e1_q[7:0], m1_q};
        big_s  = swap ? s2_q : s1_q;
        sml_s  = swap ? s1_q : s2_q;
        big_e  = swap ? e2_q : e1_q;
        sml_e  = swap ? e1_q : e2_q;
        big_m  = swap ? m2_q : m1_q;
        sml_m  = swap ? m1_q : m2_q;
        diff   = big_e - sml_e;
        sml_sh = (diff >= 10'sd25) ? 24'h0 : (sml_m >> diff[4:0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (launch) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  if (norm_exit) state_d = S_PACK;
            S_PACK:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            e1_q       <= '0;
            e2_q       <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            w_sign_q   <= 1'b0;
            w_exp_q    <= '0;
            w_mant_q   <= '0;
            norm_cnt_q <= '0;
            result     <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        s1_q       <= number1[31];
                        s2_q       <= ~number2[31];
                        e1_q       <= {2'b00, number1[30:23]};
                        e2_q       <= {2'b00, number2[30:23]};
                        m1_q       <= (number1[30:23] == 8'h0) ? 24'h0
                                      : {1'b1, number1[22:0]};
                        m2_q       <= (number2[30:23] == 8'h0) ? 24'h0
                                      : {1'b1, number2[22:0]};
                        norm_cnt_q <= '0;
                        overflow   <= 1'b0;
                        underflow  <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    s1_q    <= big_s;
                    s2_q    <= sml_s;
                    m1_q    <= big_m;
                    m2_q    <= sml_sh;
                    w_exp_q <= big_e;
                end
                S_ADD: begin
                    w_sign_q <= s1_q;
                    if (s1_q == s2_q)
                        w_mant_q <= {1'b0, m1_q} + {1'b0, m2_q};
                    else
                        w_mant_q <= {1'b0, m1_q} - {1'b0, m2_q};
                end
                S_NORM: begin
                    if (w_mant_q == 25'h0) begin
                        w_sign_q <= 1'b0;
                        w_exp_q  <= '0;
                    end else if (w_mant_q[24]) begin
                        w_mant_q <= w_mant_q >> 1;
                        w_exp_q  <= w_exp_q + 10'sd1;
                    end else if (!w_mant_q[23] && norm_cnt_q != NORM_LIM) begin
                        w_mant_q   <= w_mant_q << 1;
                        w_exp_q    <= w_exp_q - 10'sd1;
                        norm_cnt_q <= norm_cnt_q + 5'd1;
                    end
                end
                S_PACK: begin
                    if (w_exp_q >= 10'sd255) begin
                        result   <= {w_sign_q, 8'hFF, 23'h0};
                        overflow <= 1'b1;
                    end else if (w_exp_q <= 10'sd0 && w_mant_q != 25'h0) begin
                        result    <= 32'h0;
                        underflow <= 1'b1;
                    end else begin
                        result <= {w_sign_q, w_exp_q[7:0], w_mant_q[22:0]};
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
